// File: rtl/ufm_multi_page_ctrl_if.sv
// Page-engine bus between the host-side UFM controller
// and the UFMRwPage engine.
interface ufm_multi_page_ctrl_if;
  logic       er_cmd;
  logic       wr_cmd;
  logic       rd_cmd;
  logic [7:0] page_st_adrs;
  logic [7:0] page_num;
  logic [7:0] page_wr_data;
  logic [7:0] wr_dt_addrs;
  logic [7:0] rd_dt_addrs;
  logic [7:0] page_rd_data;
  logic       page_rd_cycle;
  logic       erase_end_strb;
  logic       page_wr_end_strb;
  logic       page_rd_end_strb;

  modport master (
    output er_cmd, wr_cmd, rd_cmd,
    output page_st_adrs, page_num, page_wr_data,
    input  wr_dt_addrs, rd_dt_addrs,
    input  page_rd_data, page_rd_cycle,
    input  erase_end_strb, page_wr_end_strb,
    input  page_rd_end_strb
  );

  modport slave (
    input  er_cmd, wr_cmd, rd_cmd,
    input  page_st_adrs, page_num, page_wr_data,
    output wr_dt_addrs, rd_dt_addrs,
    output page_rd_data, page_rd_cycle,
    output erase_end_strb, page_wr_end_strb,
    output page_rd_end_strb
  );
endinterface

// File: rtl/ufm_multi_page_ctrl.sv
// Multi-page UFM config-word controller: erase, program,
// read-back verify and read, with watchdog and request queue.
module ufm_multi_page_ctrl #(
  parameter int         DATA_W      = 32,
  parameter int         NUM_PAGES   = 1,
  parameter logic [7:0] START_PAGE  = 8'h00,
  parameter bit         VERIFY_EN   = 1'b1,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic              CLK_i,
  input  logic              nRst,
  input  logic              bWrPromCfg,
  input  logic              bRdPromCfg,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  ufm_multi_page_ctrl_if.master eng
);
  localparam int          NB      = DATA_W / 8;
  localparam logic [3:0]  LAST_PG = 4'(NUM_PAGES - 1);
  localparam logic [19:0] TO_CYC  = 20'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_WRITE, S_WGAP,
    S_VERIFY, S_READ, S_RGAP, S_FIN
  } state_t;

  state_t            r_state, w_nx;
  logic              r_wr_s, r_wr_d, r_rd_s, r_rd_d;
  logic              w_wr_ev, w_rd_ev;
  logic              r_wr_pend, r_rd_pend;
  logic              r_vfy, r_err;
  logic [3:0]        r_page, w_page_nx;
  logic [19:0]       r_wdog;
  logic [DATA_W-1:0] r_wbuf, r_pdata;
  logic [DATA_W-1:0] r_shadow, r_rd_data;
  logic              w_take_wr, w_take_rd;
  logic              w_to, w_copy, w_wd_exp;
  logic              w_wd_run;
  logic [7:0]        w_wr_k, w_rd_k;
  logic [7:0]        w_wr_byte, w_vexp;

  assign w_wr_ev  = r_wr_s & ~r_wr_d;
  assign w_rd_ev  = r_rd_s & ~r_rd_d;
  assign w_wd_exp = (r_wdog == TO_CYC);
  assign w_wd_run = (r_state == S_ERASE) ||
                    (r_state == S_WRITE) ||
                    (r_state == S_VERIFY) ||
                    (r_state == S_READ);

  // Map engine byte index to the word; bytes past the word read as zero
  always_comb begin
    w_wr_k    = {r_page, eng.wr_dt_addrs[3:0]};
    w_rd_k    = {r_page, eng.rd_dt_addrs[3:0]};
    w_wr_byte = 8'h00;
    w_vexp    = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (w_wr_k == 8'(i)) w_wr_byte = r_wbuf[i*8 +: 8];
      if (w_rd_k == 8'(i)) w_vexp = r_wbuf[i*8 +: 8];
    end
  end

  // Next-state, page stepping and request acceptance
  always_comb begin
    w_nx      = r_state;
    w_page_nx = r_page;
    w_take_wr = 1'b0;
    w_take_rd = 1'b0;
    w_to      = 1'b0;
    w_copy    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_ev || r_wr_pend) begin
          w_nx      = S_ERASE;
          w_page_nx = 4'd0;
          w_take_wr = 1'b1;
        end else if (w_rd_ev || r_rd_pend) begin
          w_nx      = S_READ;
          w_page_nx = 4'd0;
          w_take_rd = 1'b1;
        end
      end
      S_ERASE: begin
        if (w_wd_exp) begin
          w_to = 1'b1;
          w_nx = S_FIN;
        end else if (eng.erase_end_strb) begin
          w_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_wd_exp) begin
          w_to = 1'b1;
          w_nx = S_FIN;
        end else if (eng.page_wr_end_strb) begin
          if (r_page == LAST_PG) begin
            w_nx      = VERIFY_EN ? S_VERIFY : S_FIN;
            w_page_nx = 4'd0;
          end else begin
            w_nx      = S_WGAP;
            w_page_nx = r_page + 4'd1;
          end
        end
      end
      S_WGAP: w_nx = S_WRITE;
      S_VERIFY, S_READ: begin
        if (w_wd_exp) begin
          w_to = 1'b1;
          w_nx = S_FIN;
        end else if (eng.page_rd_end_strb) begin
          if (r_page == LAST_PG) begin
            w_nx   = S_FIN;
            w_copy = (r_state == S_READ);
          end else begin
            w_nx      = S_RGAP;
            w_page_nx = r_page + 4'd1;
          end
        end
      end
      S_RGAP: w_nx = r_vfy ? S_VERIFY : S_READ;
      S_FIN:  w_nx = S_IDLE;
    endcase
  end

  // State, page counter and per-state watchdog
  always_ff @(posedge CLK_i or negedge nRst) begin
    if (!nRst) begin
      r_state <= S_IDLE;
      r_page  <= 4'd0;
      r_wdog  <= 20'd0;
    end else begin
      r_state <= w_nx;
      r_page  <= w_page_nx;
      if (w_nx != r_state) r_wdog <= 20'd0;
      else if (w_wd_run)   r_wdog <= r_wdog + 20'd1;
    end
  end

  // Request edge detect and one-deep pending queue
  always_ff @(posedge CLK_i or negedge nRst) begin
    if (!nRst) begin
      r_wr_s    <= 1'b0;
      r_wr_d    <= 1'b0;
      r_rd_s    <= 1'b0;
      r_rd_d    <= 1'b0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_vfy     <= 1'b0;
    end else begin
      r_wr_s <= bWrPromCfg;
      r_wr_d <= r_wr_s;
      r_rd_s <= bRdPromCfg;
      r_rd_d <= r_rd_s;
      if (w_take_wr)    r_wr_pend <= 1'b0;
      else if (w_wr_ev) r_wr_pend <= 1'b1;
      if (w_take_rd)    r_rd_pend <= 1'b0;
      else if (w_rd_ev) r_rd_pend <= 1'b1;
      if (w_take_wr)      r_vfy <= 1'b1;
      else if (w_take_rd) r_vfy <= 1'b0;
    end
  end

  // Word buffers, read shadow and sticky error
  always_ff @(posedge CLK_i or negedge nRst) begin
    if (!nRst) begin
      r_wbuf    <= '0;
      r_pdata   <= '0;
      r_shadow  <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_take_wr)
        r_wbuf <= w_wr_ev ? wr_data : r_pdata;
      if (w_wr_ev && !w_take_wr)
        r_pdata <= wr_data;
      if (r_state == S_READ && eng.page_rd_cycle)
        for (int i = 0; i < NB; i++)
          if (w_rd_k == 8'(i))
            r_shadow[i*8 +: 8] <= eng.page_rd_data;
      if (w_copy) r_rd_data <= r_shadow;
      if (w_take_wr || w_take_rd)
        r_err <= 1'b0;
      else if (w_to)
        r_err <= 1'b1;
      else if (r_state == S_VERIFY &&
               eng.page_rd_cycle &&
               eng.page_rd_data != w_vexp)
        r_err <= 1'b1;
    end
  end

  assign busy    = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done    = (r_state == S_FIN);
  assign err     = r_err;
  assign rd_data = r_rd_data;

  assign eng.er_cmd       = (r_state == S_ERASE);
  assign eng.wr_cmd       = (r_state == S_WRITE);
  assign eng.rd_cmd       = (r_state == S_VERIFY) ||
                            (r_state == S_READ);
  assign eng.page_st_adrs = START_PAGE + {4'h0, r_page};
  assign eng.page_num     = 8'h01;
  assign eng.page_wr_data = w_wr_byte;
endmodule

// File: tb/tb_ufm_multi_page_ctrl.sv
// Scoreboard bench for ufm_multi_page_ctrl with a
// behavioural UFMRwPage engine model.
module tb_ufm_multi_page_ctrl;
  localparam int DW = 128;
  localparam int NP = 2;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bwr = 1'b0;
  logic          brd = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic [DW-1:0] rdat;
  logic          busy, done, err;

  always #5 clk = ~clk;

  ufm_multi_page_ctrl_if eng ();

  ufm_multi_page_ctrl #(
    .DATA_W(DW), .NUM_PAGES(NP), .START_PAGE(8'h00),
    .VERIFY_EN(1'b1), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK_i(clk), .nRst(rst_n),
    .bWrPromCfg(bwr), .bRdPromCfg(brd),
    .wr_data(wdat), .rd_data(rdat),
    .busy(busy), .done(done), .err(err),
    .eng(eng.master)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] rd;
  } resp_t;

  resp_t      exp_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] pg[$];
  int         checks = 0;
  int         errors = 0;
  int         er_cnt = 0;

  task automatic chk(input string nm,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Completion monitor: every done pops one expected response
  resp_t m_e;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 exp=0");
      end else begin
        m_e = exp_q.pop_front();
        chk("done_err", err, m_e.err);
        chk("done_rd_data", rdat, m_e.rd);
      end
    end
  end

  always @(negedge clk) if (eng.er_cmd) er_cnt++;

  // Engine model: backing memory, programmed bytes checked as sent
  logic [7:0] mem [0:31];
  logic       m_no_erase = 1'b0;
  logic       m_corrupt = 1'b0;
  int         m_cnt;
  logic       m_hold;
  logic [2:0] m_prev;
  logic [2:0] w_cmds;
  assign w_cmds = {eng.er_cmd, eng.wr_cmd, eng.rd_cmd};

  always @(posedge clk or negedge rst_n) begin : engine
    int k;
    logic [7:0] eb;
    if (!rst_n) begin
      eng.erase_end_strb   <= 1'b0;
      eng.page_wr_end_strb <= 1'b0;
      eng.page_rd_end_strb <= 1'b0;
      eng.page_rd_cycle    <= 1'b0;
      eng.page_rd_data     <= 8'h00;
      eng.wr_dt_addrs      <= 8'h00;
      eng.rd_dt_addrs      <= 8'h00;
      m_cnt  <= 0;
      m_hold <= 1'b0;
      m_prev <= 3'b000;
    end else begin
      eng.erase_end_strb   <= 1'b0;
      eng.page_wr_end_strb <= 1'b0;
      eng.page_rd_end_strb <= 1'b0;
      eng.page_rd_cycle    <= 1'b0;
      m_prev <= w_cmds;
      if (w_cmds != m_prev) begin
        m_cnt  <= 0;
        m_hold <= 1'b0;
      end else if (w_cmds != 3'b000 && !m_hold) begin
        m_cnt <= m_cnt + 1;
        if (eng.er_cmd) begin
          if (m_cnt == 3 && !m_no_erase) begin
            eng.erase_end_strb <= 1'b1;
            m_hold <= 1'b1;
          end
        end else if (eng.wr_cmd) begin
          if (m_cnt >= 1) begin
            k = int'(eng.page_st_adrs) * 16 + int'(eng.wr_dt_addrs[3:0]);
            if (k < 32) mem[k] <= eng.page_wr_data;
            if (byte_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_wr_byte got=%0h exp=none",
                       eng.page_wr_data);
            end else begin
              eb = byte_q.pop_front();
              chk("page_wr_data", eng.page_wr_data, eb);
            end
          end
          if (m_cnt < 16) begin
            eng.wr_dt_addrs <= 8'(m_cnt);
          end else begin
            eng.page_wr_end_strb <= 1'b1;
            m_hold <= 1'b1;
          end
        end else begin
          if (m_cnt < 16) begin
            k = int'(eng.page_st_adrs) * 16 + m_cnt;
            eb = (k < 32) ? mem[k] : 8'h00;
            if (m_corrupt && k == 2) eb = eb ^ 8'hFF;
            eng.rd_dt_addrs   <= 8'(m_cnt);
            eng.page_rd_data  <= eb;
            eng.page_rd_cycle <= 1'b1;
          end else begin
            eng.page_rd_end_strb <= 1'b1;
            m_hold <= 1'b1;
          end
        end
      end
    end
  end

  task automatic exp_write(input logic [DW-1:0] w);
    for (int k = 0; k < 32; k++) begin
      if (k < 16) byte_q.push_back(w[k*8 +: 8]);
      else        byte_q.push_back(8'h00);
    end
  endtask

  task automatic exp_done(input logic e, input logic [DW-1:0] rd);
    resp_t r;
    r.err = e;
    r.rd  = rd;
    exp_q.push_back(r);
  endtask

  task automatic pulse_wr(input logic [DW-1:0] d);
    @(negedge clk);
    wdat = d;
    bwr  = 1'b1;
    repeat (3) @(negedge clk);
    bwr = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    brd = 1'b1;
    repeat (3) @(negedge clk);
    brd = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=busy exp=idle", nm);
    end
  endtask

  localparam logic [DW-1:0] W1 = 128'hA5C3_0F12;
  localparam logic [DW-1:0] R2 =
    128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [DW-1:0] W3 =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] W5 =
    128'h01234567_89ABCDEF_FEDCBA98_76543210;

  initial begin
    int  gap;
    int  ngap;
    bit  ok;
    bit  prv;
    bit  seen;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_data", rdat, 0);
    chk("rst_er_cmd", eng.er_cmd, 0);
    chk("rst_wr_cmd", eng.wr_cmd, 0);
    chk("rst_rd_cmd", eng.rd_cmd, 0);
    chk("rst_page_num", eng.page_num, 8'h01);
    chk("rst_page_st_adrs", eng.page_st_adrs, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // write + verify pass
    exp_write(W1);
    exp_done(1'b0, '0);
    pulse_wr(W1);
    chk("t1_busy", busy, 1);
    chk("t1_er_cmd", eng.er_cmd, 1);
    wait_done("t1");
    chk("t1_err_idle", err, 0);

    // two-page read of 0x00..0x1F
    for (int k = 0; k < 32; k++) mem[k] = 8'(k);
    exp_done(1'b0, R2);
    pulse_rd();
    pg.delete();
    ngap = 0;
    prv  = eng.rd_cmd;
    if (prv) pg.push_back(eng.page_st_adrs);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (eng.rd_cmd && !prv) pg.push_back(eng.page_st_adrs);
      if (!eng.rd_cmd && busy) ngap++;
      prv = eng.rd_cmd;
      if (!busy) break;
    end
    chk("t2_page_count", pg.size(), 2);
    if (pg.size() == 2) begin
      chk("t2_page0", pg[0], 8'h00);
      chk("t2_page1", pg[1], 8'h01);
    end
    chk("t2_page_gap", ngap, 1);
    wait_done("t2");

    // verify mismatch on byte 2, then a read clears err
    m_corrupt = 1'b1;
    exp_write(W3);
    exp_done(1'b1, R2);
    pulse_wr(W3);
    wait_done("t3w");
    chk("t3_err_sticky", err, 1);
    m_corrupt = 1'b0;
    exp_done(1'b0, W3);
    pulse_rd();
    chk("t3_err_clr", err, 0);
    wait_done("t3r");

    // erase never ends: watchdog
    m_no_erase = 1'b1;
    er_cnt = 0;
    exp_done(1'b1, W3);
    pulse_wr(128'hDEAD);
    wait_done("t4");
    chk("t4_erase_cycles", er_cnt, TO + 1);
    chk("t4_er_cmd_low", eng.er_cmd, 0);
    m_no_erase = 1'b0;

    // simultaneous write+read edges plus a second read while busy
    exp_write(W5);
    exp_done(1'b0, W3);
    exp_done(1'b0, W5);
    @(negedge clk);
    wdat = W5;
    bwr  = 1'b1;
    brd  = 1'b1;
    repeat (3) @(negedge clk);
    bwr = 1'b0;
    brd = 1'b0;
    repeat (5) @(negedge clk);
    brd = 1'b1;
    repeat (3) @(negedge clk);
    brd = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_wr_done_seen", ok, 1);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) break;
      gap++;
    end
    chk("t5_idle_gap", gap, 1);
    wait_done("t5");
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("t5_no_extra_op", seen, 0);

    // reset in the middle of a read
    pulse_rd();
    repeat (5) @(negedge clk);
    chk("t6_rd_cmd_before", eng.rd_cmd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rd_cmd", eng.rd_cmd, 0);
    chk("t6_er_cmd", eng.er_cmd, 0);
    chk("t6_wr_cmd", eng.wr_cmd, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd_data", rdat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_page_st_adrs", eng.page_st_adrs, 8'h00);

    chk("end_resp_q_empty", exp_q.size(), 0);
    chk("end_byte_q_empty", byte_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
